// File: rtl/fir_out_requant_if.sv
// Stream/status bundle for fir_out_requant.
// slave  : the requantizer itself (consumes in_*, out_ready, clr_stats; drives out_*, stats).
// master : the surrounding logic (FIR output side plus downstream consumer).
//   in_data/in_valid  wide signed sample from the filter, no backpressure
//   out_data/out_valid/out_ready  Q1.15 result stream with backpressure
//   level             FIFO occupancy, 0..DEPTH
//   sat_flag/ovf_flag/drop_count  sticky statistics, cleared by clr_stats
interface fir_out_requant_if #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [LW-1:0]        level;
    logic                 sat_flag;
    logic                 ovf_flag;
    logic [CNT_WIDTH-1:0] drop_count;
    logic                 clr_stats;

    modport slave (
        input  in_data, in_valid, out_ready, clr_stats,
        output out_data, out_valid, level, sat_flag, ovf_flag, drop_count
    );

    modport master (
        output in_data, in_valid, out_ready, clr_stats,
        input  out_data, out_valid, level, sat_flag, ovf_flag, drop_count
    );
endinterface

// File: rtl/fir_out_requant.sv
// Requantizes the wide FIR MAC result (Q2.30) to Q1.15 with round-half-up and
// saturation, buffers it in a DEPTH-entry FIFO and presents it on ready/valid.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fir_out_requant_if.slave: input stream, output stream, occupancy, stats
module fir_out_requant #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FRAC_SHIFT = 15,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst,
    fir_out_requant_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = IN_WIDTH + 1;

    // One extra bit of headroom so the rounding add can never wrap.
    localparam logic signed [EW-1:0] HALF_V = EW'(1) <<< (FRAC_SHIFT - 1);
    localparam logic signed [EW-1:0] MAX_V  = EW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] MIN_V  = ~MAX_V;
    localparam logic [OUT_WIDTH-1:0] SAT_HI = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_LO = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [EW-1:0]  ext_c;
    logic signed [EW-1:0]  shr_c;
    logic [OUT_WIDTH-1:0]  req_c;
    logic                  clip_c;

    logic                  stg_valid_q, stg_valid_d;
    logic [OUT_WIDTH-1:0]  stg_data_q, stg_data_d;
    logic [OUT_WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  sat_q, sat_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;

    logic                  rd_c;
    logic                  wr_c;
    logic                  drop_c;

    // Round half toward +inf, shift, then clip into the output range.
    always_comb begin
        ext_c  = signed'({bus.in_data[IN_WIDTH-1], bus.in_data});
        shr_c  = (ext_c + HALF_V) >>> FRAC_SHIFT;
        req_c  = OUT_WIDTH'(shr_c);
        clip_c = 1'b0;
        if (shr_c > MAX_V) begin
            req_c  = SAT_HI;
            clip_c = 1'b1;
        end else if (shr_c < MIN_V) begin
            req_c  = SAT_LO;
            clip_c = 1'b1;
        end
    end

    // FIFO control: a write into a full FIFO is legal only when the head leaves on the same edge.
    always_comb begin
        rd_c   = (level_q != '0) && bus.out_ready;
        wr_c   = stg_valid_q && ((level_q < LW'(DEPTH)) || rd_c);
        drop_c = stg_valid_q && !wr_c;

        stg_valid_d = bus.in_valid;
        stg_data_d  = bus.in_valid ? req_c : stg_data_q;
        wr_ptr_d    = wr_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d     = level_q;
        if (wr_c && !rd_c) begin
            level_d = level_q + LW'(1);
        end else if (!wr_c && rd_c) begin
            level_d = level_q - LW'(1);
        end
    end

    // Sticky statistics; a new event on the clearing edge takes precedence.
    always_comb begin
        sat_d  = sat_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (bus.clr_stats) begin
            sat_d  = 1'b0;
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        if (bus.in_valid && clip_c) begin
            sat_d = 1'b1;
        end
        if (drop_c) begin
            ovf_d = 1'b1;
            if (bus.clr_stats) begin
                drop_d = CNT_WIDTH'(1);
            end else if (!(&drop_q)) begin
                drop_d = drop_q + CNT_WIDTH'(1);
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_data_q  <= stg_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    // Storage array; contents are only observable through a non-zero level.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem_q[wr_ptr_q] <= stg_data_q;
        end
    end

    // Head is forced to zero while empty so the output reads 0 after reset.
    assign bus.out_data   = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.out_valid  = (level_q != '0);
    assign bus.level      = level_q;
    assign bus.sat_flag   = sat_q;
    assign bus.ovf_flag   = ovf_q;
    assign bus.drop_count = drop_q;
endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Consumer-side block for the team's FIR filter output stream.
- Takes the wide signed MAC result (Q2.30 for Q1.15 data × Q1.15 coeffs), rounds and saturates it back to Q1.15, and buffers it in a FIFO.
- Presents the result on a ready/valid interface so downstream logic can apply backpressure, which the FIR itself cannot accept.
- Also reports saturation and overflow/drop statistics.

Parameters:
- IN_WIDTH, 32, width of signed input sample (DATA_WIDTH+COEFF_WIDTH of the upstream filter)
- OUT_WIDTH, 16, width of signed output sample
- FRAC_SHIFT, 15, arithmetic right shift applied after rounding (≥1)
- DEPTH, 8, FIFO depth in entries (power of two, ≥2)
- CNT_WIDTH, 16, width of drop counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- in_data  in  IN_WIDTH  signed wide sample from filter
- in_valid  in  1  in_data valid this cycle; no backpressure upstream
- out_data  out  OUT_WIDTH  signed rounded/saturated sample at FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts out_data when out_valid&&out_ready
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- sat_flag  out  1  sticky: a sample was clipped
- ovf_flag  out  1  sticky: a sample was dropped (FIFO full)
- drop_count  out  CNT_WIDTH  number of dropped samples, saturating
- clr_stats  in  1  synchronous clear of sat_flag, ovf_flag, drop_count

Behaviour:
- Reset (async, rst=1): FIFO pointers/level=0, out_valid=0, out_data=0, stage register invalid, sat_flag=0, ovf_flag=0, drop_count=0. Reset mid-operation discards all buffered and in-flight samples immediately.
- Stage 1 (registered on edge E0 where in_valid=1):
  - r = (in_data sign-extended to IN_WIDTH+1) + 2^(FRAC_SHIFT-1), then arithmetic shift right by FRAC_SHIFT.
  - This rounds half toward +inf. No intermediate overflow is permitted.
  - If r > 2^(OUT_WIDTH-1)-1, output 0x7FFF; if r < -2^(OUT_WIDTH-1), output 0x8000; otherwise r truncated to OUT_WIDTH.
  - A clip sets sat_flag on the same edge.
- Stage 2 (edge E1): valid stage value is written to FIFO tail.
  - Write is accepted if level<DEPTH, or if level==DEPTH and a read occurs on the same edge.
  - Otherwise the sample is dropped: ovf_flag set, drop_count += 1, saturating at all-ones.
- Latency: in_valid at E0 → out_valid=1 after E1 when the FIFO was empty. Sustains one sample per cycle.
- Output: out_data = FIFO head (combinational from memory at read pointer); out_valid = (level!=0).
  - out_data and out_valid stay stable while out_valid&&!out_ready.
  - out_data is don't-care when out_valid=0 but is 0 after reset.
- Read: on an edge with out_valid&&out_ready, the head advances.
- Simultaneous read and write: level unchanged; valid at any level, including empty→write only, and full→both.
- Pointers wrap modulo DEPTH. level covers 0..DEPTH inclusive.
- clr_stats=1 clears stats on that edge. If a sat/drop event occurs on the same edge, the event wins: flag=1, drop_count=1 for a drop.
- FIFO order is strictly preserved. No sample is duplicated or reordered.

Test Plan:
- Rounding: in_data 0x0000_4000 → 0x0001; 0x0000_3FFF → 0x0000; 0xFFFF_C000 → 0x0000; 0xFFFF_BFFF → 0xFFFF. sat_flag stays 0.
- Scaling: 0x2000_0000 → 0x4000. Filter DC case 32767×32768 = 0x3FFF_8000 → 0x7FFF with sat_flag=0.
- Saturation: 0x4000_0000 → 0x7FFF, sat_flag=1. 0x8000_0000 → 0x8000. clr_stats pulse → sat_flag=0.
- Latency/streaming: out_ready=1, 20 back-to-back in_valid samples → out_valid rises 2 edges after first in_valid, 20 outputs in order, level ≤1.
- Backpressure/overflow (DEPTH=8): out_ready=0, 10 samples in → level=8, drop_count=2, ovf_flag=1. Then out_ready=1 → first 8 samples drained in order, level reaches 0, out_valid=0.
- Full with simultaneous read/write, and reset mid-stream: with level=8, in_valid with out_ready=1 → no drop, level stays 8. Assert rst asynchronously mid-burst → all outputs and flags 0 immediately, the next sample after release emerges correctly.
